mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM pipeline stage: internal EX/MEM register, data-memory req/ack handshake
//  with stall generation, byte/half/word access with byte enables and load sign/zero extension.
//  Sits between the EX stage and MEM/WB register; drives an external variable-latency data memory.
// PARAMETERS
//  DATA_W  32  datapath width (multiple of 8; size encodings assume >=32)
//  ADDR_W  32  byte address width
//  REG_W   5   destination register index width
// PORTS
//  clk            in   1         rising-edge clock
//  rst_n          in   1         reset, asynchronous, active-low
//  ex_valid       in   1         EX stage presents a valid instruction
//  branch_in, mem_read, mem_write, reg_write, mem_to_reg  in 1 each  control from EX
//  mem_size       in   2         00 byte, 01 half, 10 word (11 = word)
//  mem_unsigned   in   1         1 = zero-extend loads
//  zero           in   1         ALU zero flag
//  branch_addr    in   ADDR_W    branch target
//  alu_res        in   DATA_W    ALU result / effective address
//  write_data     in   DATA_W    store data
//  rd             in   REG_W     destination register
//  stall          out  1         hold EX/MEM and all upstream stages
//  dmem_req       out  1         memory request valid
//  dmem_we        out  1         1 = store
//  dmem_addr      out  ADDR_W    address, low log2(DATA_W/8) bits zero
//  dmem_wdata     out  DATA_W    lane-replicated store data
//  dmem_be        out  DATA_W/8  byte enables
//  dmem_ack       in   1         request completed this cycle
//  dmem_rdata     in   DATA_W    load data, valid with dmem_ack
//  mem_valid      out  1         registered instruction valid
//  alu_res_out    out  DATA_W;  branch_addr_out out ADDR_W;  rd_out out REG_W
//  read_data      out  DATA_W    aligned, extended load result
//  wb_out         out  2         {reg_write, mem_to_reg}, gated by mem_valid
//  branch         out  1         branch taken = branch_q & zero_q & mem_valid
// BEHAVIOUR
//  - Reset: all registers, outputs 0; FSM -> IDLE. Reset mid-request drops dmem_req immediately.
//  - EX/MEM register loads on clk when !stall; ex_valid=0 loads a bubble (all controls 0).
//  - FSM IDLE/BUSY/DONE. mem_op = mem_valid & (mem_read_q | mem_write_q); read wins if both set.
//    IDLE: mem_op -> dmem_req=1 combinationally; ack -> DONE else BUSY.
//    BUSY: dmem_req=1; ack -> DONE.  DONE: req=0; -> IDLE (new instr loads same edge).
//  - stall = mem_op & (state != DONE). Zero-wait memory: 2 cycles per memory op; N wait -> 2+N.
//  - Non-memory instr: no stall, 1 cycle in stage.
//  - Load data captured on ack into read_data register; held until next load completes.
//  - Byte enables (lane = addr[1:0]): byte -> 1<<lane; half -> 0011/1100 by addr[1]; word -> all.
//    Store data replicated to all lanes of the size. Load: select lane, sign/zero extend to DATA_W.
//  - branch uses registered zero (same instruction as branch_q); never asserted during reset.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0 issues no request,
//   no stall, pulses extra output misalign_trap (1 cycle), forces wb_out reg_write bit to 0.
//  Undefined: no misalign_trap port; misaligned address silently aligned down to size.
// STRUCTURE
//  mem_pkg: mem_size encodings (MEM_B/MEM_H/MEM_W), FSM state enum/localparams.
//  Sub-module load_align: combinational lane select + extend (rdata, addr[1:0], size, unsigned).
// TESTING
//  1 lw addr 0x10, ack same cycle, rdata 0xDEADBEEF -> stall 1 cycle, read_data=0xDEADBEEF, wb_out=11.
//  2 lb addr 0x13, rdata 0x80FFFFFF -> be=1000, read_data=0xFFFFFF80; lbu -> 0x00000080.
//  3 sh addr 0x22, write_data 0x1234 -> be=1100, wdata=0x12341234, dmem_we=1, 3 ack waits -> stall 4 cyc.
//  4 beq zero=1 branch_in=1 addr 0x40 -> branch=1, branch_addr_out=0x40 one cycle after capture.
//  5 rst_n low while BUSY -> dmem_req, stall, mem_valid 0 immediately; restart in IDLE.
//  6 lw addr 0x12 -> TRAP_EN: misalign_trap=1, no req, wb_out=01; else dmem_addr=0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, handshake FSM states and a size helper.
package mem_pkg;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Access span in bytes minus one; doubles as the lane alignment mask (0, 1, 3).
   function automatic logic [2:0] size_bytes_m1(input logic [1:0] sz);
      case (sz)
         MEM_B:   size_bytes_m1 = 3'd0;
         MEM_H:   size_bytes_m1 = 3'd1;
         MEM_W:   size_bytes_m1 = 3'd3;
         default: size_bytes_m1 = 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and sign/zero extends it.
module load_align
#(
   parameter int DATA_W = 32
)
(
   input  logic [DATA_W-1:0]            rdata,
   input  logic [$clog2(DATA_W/8)-1:0]  lane,
   input  logic [1:0]                   size,
   input  logic                         is_unsigned,
   output logic [DATA_W-1:0]            data
);
   import mem_pkg::*;

   logic [DATA_W-1:0] shifted;

   always_comb begin
      shifted = rdata >> {lane, 3'b000};
      data    = '0;
      case (size)
         MEM_B:   data = is_unsigned ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
         MEM_H:   data = is_unsigned ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
         default: data = is_unsigned ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      endcase
   end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with EX/MEM register and req/ack data-memory handshake that stalls upstream.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module mem_stage_hs
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  branch_in,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  reg_write,
   input  logic                  mem_to_reg,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic                  zero,
   input  logic [ADDR_W-1:0]     branch_addr,
   input  logic [DATA_W-1:0]     alu_res,
   input  logic [DATA_W-1:0]     write_data,
   input  logic [REG_W-1:0]      rd,
   output logic                  stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   output logic [DATA_W/8-1:0]   dmem_be,
   input  logic                  dmem_ack,
   input  logic [DATA_W-1:0]     dmem_rdata,
   output logic                  mem_valid,
   output logic [DATA_W-1:0]     alu_res_out,
   output logic [ADDR_W-1:0]     branch_addr_out,
   output logic [REG_W-1:0]      rd_out,
   output logic [DATA_W-1:0]     read_data,
   output logic [1:0]            wb_out,
   output logic                  branch
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                  misalign_trap
`endif
);

   localparam int NB  = DATA_W / 8;
   localparam int OFF = $clog2(NB);

   logic              valid_q, branch_q, mem_read_q, mem_write_q;
   logic              reg_write_q, mem_to_reg_q, zero_q, unsigned_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] branch_addr_q;
   logic [DATA_W-1:0] alu_res_q, write_data_q, read_data_q;
   logic [REG_W-1:0]  rd_q;
   state_e            state_q, state_d;

   logic [2:0]        span_m1;
   logic [OFF-1:0]    lane_raw, lane;
   logic [DATA_W-1:0] load_data;
   logic              mem_op;

   assign span_m1  = size_bytes_m1(size_q);
   assign lane_raw = alu_res_q[OFF-1:0];
   // Misaligned accesses fall back to the naturally aligned lane of their size.
   assign lane     = lane_raw & ~OFF'(span_m1);

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned    = (span_m1[0] & lane_raw[0]) | (span_m1[1] & lane_raw[1]);
   assign misalign_trap = valid_q & (mem_read_q | mem_write_q) & misaligned;
   assign mem_op        = valid_q & (mem_read_q | mem_write_q) & ~misaligned;
   assign wb_out        = {reg_write_q & valid_q & ~misalign_trap, mem_to_reg_q & valid_q};
`else
   assign mem_op        = valid_q & (mem_read_q | mem_write_q);
   assign wb_out        = {reg_write_q & valid_q, mem_to_reg_q & valid_q};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         branch_q      <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         zero_q        <= 1'b0;
         unsigned_q    <= 1'b0;
         size_q        <= 2'b00;
         branch_addr_q <= '0;
         alu_res_q     <= '0;
         write_data_q  <= '0;
         rd_q          <= '0;
         read_data_q   <= '0;
      end else begin
         if (!stall) begin
            valid_q       <= ex_valid;
            branch_q      <= ex_valid & branch_in;
            mem_read_q    <= ex_valid & mem_read;
            mem_write_q   <= ex_valid & mem_write;
            reg_write_q   <= ex_valid & reg_write;
            mem_to_reg_q  <= ex_valid & mem_to_reg;
            zero_q        <= zero;
            unsigned_q    <= mem_unsigned;
            size_q        <= mem_size;
            branch_addr_q <= branch_addr;
            alu_res_q     <= alu_res;
            write_data_q  <= write_data;
            rd_q          <= rd;
         end
         if (dmem_req && dmem_ack && mem_read_q)
            read_data_q <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      stall    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               dmem_req = 1'b1;
               stall    = 1'b1;
               state_d  = dmem_ack ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            dmem_req = 1'b1;
            stall    = 1'b1;
            if (dmem_ack) state_d = ST_DONE;
         end
         // Stall drops here so the next instruction loads on the same edge we return to IDLE.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dmem_wdata = '0;
      for (int i = 0; i < NB; i++)
         dmem_wdata[8*i +: 8] = write_data_q[8*(i & 32'(span_m1)) +: 8];
   end

   assign dmem_be   = NB'({span_m1[1], span_m1[1], span_m1[0], 1'b1}) << lane;
   assign dmem_addr = ADDR_W'(alu_res_q) & ~ADDR_W'(NB - 1);
   assign dmem_we   = dmem_req & mem_write_q & ~mem_read_q;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .rdata       (dmem_rdata),
      .lane        (lane),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .data        (load_data)
   );

   assign mem_valid       = valid_q;
   assign alu_res_out     = alu_res_q;
   assign branch_addr_out = branch_addr_q;
   assign rd_out          = rd_q;
   assign read_data       = read_data_q;
   assign branch          = branch_q & zero_q & valid_q;

endmodule
